// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM: one shared period counter feeding per-channel double-buffered compare stages.
// Define PWM_CENTER_ALIGN_EN to build up/down (center-aligned) counting selected by centerMode.
module pwm_channel_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [WIDTH-1:0]            top,
    input  logic                        centerMode,
    input  logic [CHANNELS-1:0]         channelEnable,
    input  logic [CHANNELS-1:0]         invert,
    input  logic [CHANNELS*WIDTH-1:0]   compareValues,
    output logic [WIDTH-1:0]            counterValue,
    output logic                        periodStart,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [CHANNELS-1:0]         compareRise,
    output logic [CHANNELS-1:0]         compareFall
);

    logic [WIDTH-1:0]                 cnt_q, cnt_d;
    logic [WIDTH-1:0]                 top_q, top_d;
    logic                             dir_d;
    logic                             load;
    logic [CHANNELS-1:0][WIDTH-1:0]   cmp_q, cmp_d;
    logic [CHANNELS-1:0]              state_q, state_d;
    logic [CHANNELS-1:0]              last_q;
    logic [CHANNELS-1:0]              rise_q, fall_q;
    logic                             period_q, period_d;

`ifdef PWM_CENTER_ALIGN_EN
    logic                             dir_q;
    logic                             mode_q, mode_d;
`else
    logic                             unused_center;
    assign unused_center = centerMode;
`endif

    // Next counter value; a zero top or a disabled bank pins the counter at 0 going "up".
    always_comb begin
        cnt_d = '0;
        dir_d = 1'b0;
        if (enable && (top_q != '0)) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (mode_q) begin
                if (!dir_q) begin
                    cnt_d = cnt_q + 1'b1;
                    dir_d = (cnt_d == top_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = (cnt_d != '0);
                end
            end else begin
                cnt_d = (cnt_q == top_q) ? '0 : cnt_q + 1'b1;
            end
`else
            cnt_d = (cnt_q == top_q) ? '0 : cnt_q + 1'b1;
`endif
        end
    end

    // Shadow registers only reload at the start of a period, never mid-period.
    assign load     = (cnt_d == '0) && !dir_d;
    assign top_d    = load ? top : top_q;
    assign period_d = enable && load;

`ifdef PWM_CENTER_ALIGN_EN
    assign mode_d = load ? centerMode : mode_q;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign cmp_d[gi]   = load ? compareValues[gi*WIDTH +: WIDTH] : cmp_q[gi];
            assign state_d[gi] = channelEnable[gi] & enable & (cnt_d < cmp_d[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            top_q    <= '0;
            cmp_q    <= '0;
            state_q  <= '0;
            last_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            period_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            top_q    <= top_d;
            cmp_q    <= cmp_d;
            state_q  <= state_d;
            last_q   <= state_q;
            rise_q   <= state_q & ~last_q;
            fall_q   <= last_q & ~state_q;
            period_q <= period_d;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            mode_q <= mode_d;
        end
    end
`endif

    assign counterValue = cnt_q;
    assign periodStart  = period_q;
    assign pwm_out      = state_q ^ invert;
    assign compareRise  = rise_q;
    assign compareFall  = fall_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank: vector table for edge-mode operation plus hand sequences.
module tb_pwm_channel_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [W-1:0]    top;
    logic            centerMode;
    logic [CH-1:0]   channelEnable;
    logic [CH-1:0]   invert;
    logic [CH*W-1:0] compareValues;
    logic [W-1:0]    counterValue;
    logic            periodStart;
    logic [CH-1:0]   pwm_out;
    logic [CH-1:0]   compareRise;
    logic [CH-1:0]   compareFall;

    int errors = 0;
    int checks = 0;

    pwm_channel_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .top(top), .centerMode(centerMode),
        .channelEnable(channelEnable), .invert(invert), .compareValues(compareValues),
        .counterValue(counterValue), .periodStart(periodStart), .pwm_out(pwm_out),
        .compareRise(compareRise), .compareFall(compareFall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [CH-1:0] inv;
        logic [W-1:0]  cmp1;
        logic [W-1:0]  cnt;
        logic [CH-1:0] pwm;
        logic          ps;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic en, input logic [CH-1:0] inv, input logic [W-1:0] cmp1,
                              input logic [W-1:0] cnt, input logic [CH-1:0] pwm, input logic ps,
                              input logic [CH-1:0] rise, input logic [CH-1:0] fall);
        vecs.push_back('{en, inv, cmp1, cnt, pwm, ps, rise, fall});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] cnt, input logic [CH-1:0] pwm,
                           input logic ps, input logic [CH-1:0] rise, input logic [CH-1:0] fall);
        chk({tag, ".cnt"},  32'(counterValue), 32'(cnt));
        chk({tag, ".pwm"},  32'(pwm_out),      32'(pwm));
        chk({tag, ".ps"},   32'(periodStart),  32'(ps));
        chk({tag, ".rise"}, 32'(compareRise),  32'(rise));
        chk({tag, ".fall"}, 32'(compareFall),  32'(fall));
        $display("%s cnt=%0d pwm=%b ps=%b rise=%b fall=%b", tag, counterValue, pwm_out,
                 periodStart, compareRise, compareFall);
    endtask

    initial begin
        int c;
        // Edge mode, top=9, compare {ch3=255, ch2=10, ch1, ch0=0}
        v(0, 4'b0000, 3, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 1, 4'b1110, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 2, 4'b1110, 0, 4'b1110, 4'b0000);
        v(1, 4'b0000, 3, 3, 4'b1100, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 4, 4'b1100, 0, 4'b0000, 4'b0010);
        for (int i = 5; i <= 9; i++) v(1, 4'b0000, 3, W'(i), 4'b1100, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 0, 4'b1110, 1, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 1, 4'b1110, 0, 4'b0010, 4'b0000);
        v(1, 4'b0000, 3, 2, 4'b1110, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 3, 4'b1100, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 3, 4, 4'b1100, 0, 4'b0000, 4'b0010);
        // Inverted ch1: output complemented, events unchanged
        for (int i = 5; i <= 9; i++) v(1, 4'b0010, 3, W'(i), 4'b1110, 0, 4'b0000, 4'b0000);
        v(1, 4'b0010, 3, 0, 4'b1100, 1, 4'b0000, 4'b0000);
        v(1, 4'b0010, 3, 1, 4'b1100, 0, 4'b0010, 4'b0000);
        v(1, 4'b0010, 3, 2, 4'b1100, 0, 4'b0000, 4'b0000);
        v(1, 4'b0010, 3, 3, 4'b1110, 0, 4'b0000, 4'b0000);
        v(1, 4'b0010, 3, 4, 4'b1110, 0, 4'b0000, 4'b0010);
        // Compare 3->6 at counter 4: takes effect only next period
        for (int i = 5; i <= 9; i++) v(1, 4'b0000, 6, W'(i), 4'b1100, 0, 4'b0000, 4'b0000);
        v(1, 4'b0000, 6, 0, 4'b1110, 1, 4'b0000, 4'b0000);
        v(1, 4'b0000, 6, 1, 4'b1110, 0, 4'b0010, 4'b0000);
        for (int i = 2; i <= 5; i++) v(1, 4'b0000, 6, W'(i), 4'b1110, 0, 4'b0000, 4'b0000);
        // Disable while high: state drops, fall pulse one cycle later
        v(0, 4'b0000, 6, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(0, 4'b0000, 6, 0, 4'b0000, 0, 4'b0000, 4'b1110);
        v(0, 4'b0000, 6, 0, 4'b0000, 0, 4'b0000, 4'b0000);

        rst = 1'b1; enable = 1'b0; top = 8'd9; centerMode = 1'b0;
        channelEnable = 4'hF; invert = 4'b1001;
        compareValues = {8'd255, 8'd10, 8'd3, 8'd0};
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 4'b1001, 0, 4'b0000, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            enable        = vecs[i].en;
            invert        = vecs[i].inv;
            compareValues = {8'd255, 8'd10, vecs[i].cmp1, 8'd0};
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pwm, vecs[i].ps,
                    vecs[i].rise, vecs[i].fall);
        end

        // Asynchronous reset at counter 5 with ch1 high
        enable = 1'b1; invert = 4'b0101;
        repeat (5) step();
        chk("pre_rst.cnt", 32'(counterValue), 32'd5);
        chk("pre_rst.pwm", 32'(pwm_out), 32'(4'b1011));
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 4'b0101, 0, 4'b0000, 4'b0000);
        step();
        chk_all("rst_hold", 0, 4'b0101, 0, 4'b0000, 4'b0000);
        rst = 1'b0; invert = 4'b0000;
        step();
        chk_all("rst_rel0", 0, 4'b1110, 1, 4'b0000, 4'b0000);
        step();
        chk_all("rst_rel1", 1, 4'b1110, 0, 4'b1110, 4'b0000);

        // top=0: counter stuck at 0, periodStart every cycle, high iff compare>0
        top = 8'd0; enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("top0_%0d.cnt", k), 32'(counterValue), 32'd0);
            chk($sformatf("top0_%0d.ps", k),  32'(periodStart),  32'd1);
            chk($sformatf("top0_%0d.pwm", k), 32'(pwm_out),      32'(4'b1110));
        end

        // Center request with top=8, compare ch1=4
        top = 8'd8; centerMode = 1'b1; enable = 1'b0;
        compareValues = {8'd255, 8'd10, 8'd4, 8'd0};
        step();
        enable = 1'b1;
        for (int k = 1; k <= 34; k++) begin
`ifdef PWM_CENTER_ALIGN_EN
            c = ((k % 16) <= 8) ? (k % 16) : 16 - (k % 16);
`else
            c = k % 9;
`endif
            step();
            chk($sformatf("ctr%0d.cnt", k), 32'(counterValue), 32'(c));
            chk($sformatf("ctr%0d.ps", k),  32'(periodStart),  32'(c == 0));
            chk($sformatf("ctr%0d.pwm", k), 32'(pwm_out), 32'({2'b11, (c < 4), 1'b0}));
            $display("ctr%0d cnt=%0d ps=%b pwm=%b", k, counterValue, periodStart, pwm_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_channel_bank.md
# pwm_channel_bank

Multi-channel PWM generator with one shared period counter and per-channel double-buffered compare registers, polarity control and edge-event pulses. It generalises the single-output PWM compare stage: it owns its own counter with a programmable period, supports any channel count and width, and optionally center-aligned counting. It sits behind the PWM peripheral register block, which drives the configuration ports and consumes the event pulses as interrupt sources.

## Interface
- CHANNELS, 4, number of PWM outputs (≥1)
- WIDTH, 16, counter and compare width (≥2)

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  global counter run; low holds counter at 0
- top  input  WIDTH  period top value (shadowed)
- centerMode  input  1  1 = up/down counting; ignored without PWM_CENTER_ALIGN_EN
- channelEnable  input  CHANNELS  per-channel output enable
- invert  input  CHANNELS  per-channel output polarity; not shadowed
- compareValues  input  CHANNELS*WIDTH  channel n at [n*WIDTH +: WIDTH] (shadowed)
- counterValue  output  WIDTH  current counter
- periodStart  output  1  one-cycle pulse at each period start
- pwm_out  output  CHANNELS  PWM outputs
- compareRise  output  CHANNELS  one-cycle pulse after channel state 0→1
- compareFall  output  CHANNELS  one-cycle pulse after channel state 1→0

## Operation
- Registers: counter c, direction d (0 = up), activeTop, activeCompare[n], state[n], periodStart, compareRise/Fall, lastState[n].
- Counter next value cn: enable=0 → 0, d=0; edge mode → (c==activeTop) ? 0 : c+1; center mode → count up to activeTop, then down to 0; d flips on the edge where c reaches activeTop (up) or 0 (down).
- Shadow load: on every edge where cn==0 and (edge mode or d=0 after update), activeTop←top and activeCompare[n]←compareValues[n]. Loads continuously while enable=0. No mid-period updates.
- state[n] next = channelEnable[n] & enable & (cn < activeCompare'[n]), where activeCompare' is the value in effect for cn (the newly loaded value on a load edge). Thus state aligns with counterValue.
- pwm_out[n] = state[n] ^ invert[n] (combinational output stage).
- compare=0 → always low; compare>activeTop → always high; no events in either case.
- compareRise[n]/compareFall[n] registered from state[n] vs lastState[n]; inversion does not affect them.
- periodStart registered: enable & (cn==0) & (edge mode or d=0 next).
- Edge mode period = activeTop+1 cycles; center mode period = 2*activeTop cycles; activeTop=0 in either mode → counter stuck at 0, periodStart high every cycle.
- Mode switch: centerMode sampled only on shadow-load edges (shadowed with top).

## Timing
- Reset values: counterValue 0, d 0, activeTop 0, activeCompare 0, state 0, periodStart 0, compareRise/Fall 0; pwm_out = invert.
- Reset mid-period: all registers return to reset values asynchronously; after release counter restarts at 0 on the first edge.
- pwm_out transitions same cycle as the counterValue that causes them; compareRise/Fall lag pwm_out by 1 cycle.
- enable rising: counter 1 on first enabled edge; first periodStart at the first wrap (the disabled cycle at 0 is not a period start).
- enable falling: next edge counter 0, all state 0, a compareFall pulse follows for channels that were high.
- channelEnable low mid-period: state 0 next edge, compareFall if was high.
- invert changes take effect combinationally, no events.

## Configuration
- PWM_CENTER_ALIGN_EN defined: direction register and up/down counting built; centerMode honoured.
- Not defined: no direction logic; centerMode ignored; edge-aligned counting only.

## Test plan
- CHANNELS=4, WIDTH=8, top=9, compare={0,3,10,255}, enable=1 → period 10 cycles; ch0 always low, ch1 high for counter 0–2, ch2/ch3 always high; periodStart every 10 cycles; rise/fall only on ch1.
- Change compare ch1 3→6 at counter=4 → current period keeps 3; next period high for 0–5.
- invert=4'b0010 with ch1 running → pwm_out[1] complemented, compareRise/Fall timing unchanged.
- Center mode (macro on), top=8, compare=4 → period 16 cycles, high while counter<4 on both slopes, periodStart only at counter 0 going up.
- Assert rst at counter=5 with ch1 high → counterValue 0, pwm_out=invert, no event pulses, restart from 0 after release.
- top=0, enable=1 → counter 0 constant, periodStart constant 1, pwm_out high iff compare>0.
